// File: rtl/riscv_pkg.sv
// Shared definitions for the multicycle RV32I/RV32E core.
package riscv_pkg;

   localparam logic [6:0] OPC_LUI    = 7'b0110111;
   localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
   localparam logic [6:0] OPC_JAL    = 7'b1101111;
   localparam logic [6:0] OPC_JALR   = 7'b1100111;
   localparam logic [6:0] OPC_BRANCH = 7'b1100011;
   localparam logic [6:0] OPC_LOAD   = 7'b0000011;
   localparam logic [6:0] OPC_STORE  = 7'b0100011;
   localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
   localparam logic [6:0] OPC_OP     = 7'b0110011;

   localparam logic [2:0] F3_ADD  = 3'b000;
   localparam logic [2:0] F3_SLL  = 3'b001;
   localparam logic [2:0] F3_SLT  = 3'b010;
   localparam logic [2:0] F3_SLTU = 3'b011;
   localparam logic [2:0] F3_XOR  = 3'b100;
   localparam logic [2:0] F3_SR   = 3'b101;
   localparam logic [2:0] F3_OR   = 3'b110;
   localparam logic [2:0] F3_AND  = 3'b111;
   localparam logic [2:0] F3_BEQ  = 3'b000;
   localparam logic [2:0] F3_BNE  = 3'b001;
   localparam logic [2:0] F3_BLT  = 3'b100;
   localparam logic [2:0] F3_BGE  = 3'b101;
   localparam logic [2:0] F3_BLTU = 3'b110;
   localparam logic [2:0] F3_BGEU = 3'b111;
   localparam logic [2:0] F3_WORD = 3'b010;

   localparam logic [6:0] F7_BASE = 7'b0000000;
   localparam logic [6:0] F7_ALT  = 7'b0100000;

   typedef enum logic [3:0] {
      ALU_ADD   = 4'd0,
      ALU_SUB   = 4'd1,
      ALU_SLL   = 4'd2,
      ALU_SLT   = 4'd3,
      ALU_SLTU  = 4'd4,
      ALU_XOR   = 4'd5,
      ALU_SRL   = 4'd6,
      ALU_SRA   = 4'd7,
      ALU_OR    = 4'd8,
      ALU_AND   = 4'd9,
      ALU_PASSB = 4'd10
   } alu_op_e;

   typedef enum logic [2:0] {
      S_FETCH, S_DECODE, S_EXEC, S_MEM, S_WB, S_HALT
   } state_e;

   typedef enum logic [2:0] {
      IMM_I, IMM_S, IMM_B, IMM_U, IMM_J
   } imm_e;

   // funct3 plus the "alternate" bit (SUB/SRA) to ALU operation
   function automatic alu_op_e alu_dec(input logic [2:0] f3, input logic alt);
      case (f3)
         F3_ADD:  return alt ? ALU_SUB : ALU_ADD;
         F3_SLL:  return ALU_SLL;
         F3_SLT:  return ALU_SLT;
         F3_SLTU: return ALU_SLTU;
         F3_XOR:  return ALU_XOR;
         F3_SR:   return alt ? ALU_SRA : ALU_SRL;
         F3_OR:   return ALU_OR;
         default: return ALU_AND;
      endcase
   endfunction

   function automatic logic [31:0] alu_exec(input alu_op_e op, input logic [31:0] a,
                                            input logic [31:0] b);
      case (op)
         ALU_ADD:   return a + b;
         ALU_SUB:   return a - b;
         ALU_SLL:   return a << b[4:0];
         ALU_SLT:   return {31'd0, $signed(a) < $signed(b)};
         ALU_SLTU:  return {31'd0, a < b};
         ALU_XOR:   return a ^ b;
         ALU_SRL:   return a >> b[4:0];
         ALU_SRA:   return $signed(a) >>> b[4:0];
         ALU_OR:    return a | b;
         ALU_AND:   return a & b;
         ALU_PASSB: return b;
         default:   return 32'd0;
      endcase
   endfunction

endpackage

// File: rtl/riscv_multicycle_if.sv
// Unified instruction/data memory port with a ready handshake.
interface riscv_multicycle_if;
   logic        mem_req;
   logic        mem_we;
   logic [31:0] mem_addr;
   logic [31:0] mem_wdata;
   logic [31:0] mem_rdata;
   logic        mem_ready;

   modport master (output mem_req, mem_we, mem_addr, mem_wdata,
                   input  mem_rdata, mem_ready);
   modport slave  (input  mem_req, mem_we, mem_addr, mem_wdata,
                   output mem_rdata, mem_ready);
endinterface

// File: rtl/riscv_regfile.sv
// Register file: two async read ports, one sync write port, x0 hard-wired to zero.
module riscv_regfile #(
   parameter int NUM_REGS = 32
) (
   input  logic        clk,
   input  logic        rst,
   input  logic [4:0]  raddr1,
   input  logic [4:0]  raddr2,
   output logic [31:0] rdata1,
   output logic [31:0] rdata2,
   input  logic        we,
   input  logic [4:0]  waddr,
   input  logic [31:0] wdata
);
   localparam int AW = $clog2(NUM_REGS);

   logic [31:0] rf [NUM_REGS];

   function automatic logic in_range(input logic [4:0] r);
      return {27'd0, r} < 32'(NUM_REGS);
   endfunction

   // synchronous clear, otherwise write any in-range register except x0
   always_ff @(posedge clk) begin
      if (!rst) begin
         for (int i = 0; i < NUM_REGS; i++) rf[i] <= '0;
      end else if (we && waddr != 5'd0 && in_range(waddr)) begin
         rf[waddr[AW-1:0]] <= wdata;
      end
   end

   assign rdata1 = (raddr1 == 5'd0 || !in_range(raddr1)) ? '0 : rf[raddr1[AW-1:0]];
   assign rdata2 = (raddr2 == 5'd0 || !in_range(raddr2)) ? '0 : rf[raddr2[AW-1:0]];
endmodule

// File: rtl/riscv_multicycle.sv
// Multicycle RV32I/RV32E core: shared ALU, unified memory port, halt on trap.
module riscv_multicycle
   import riscv_pkg::*;
#(
   parameter logic [31:0] RESET_PC = 32'h0000_0000,
   parameter int          NUM_REGS = 32
) (
   input  logic                 clk,
   input  logic                 rst,
   riscv_multicycle_if.master   mem,
   output logic [31:0]          PC,
   output logic                 retire,
   output logic                 halted
);
   state_e      state;
   logic        in_rst;     // rst was sampled low on the last edge
   logic [31:0] ir, a_q, b_q, alu_out, mdr, npc;
   logic [31:0] rd1, rd2, imm, alu_a, alu_b, alu_res, jtgt, pc4;
   alu_op_e     alu_op;
   imm_e        imm_sel;
   logic        taken, legal;

   wire [6:0] opc = ir[6:0];
   wire [2:0] f3  = ir[14:12];
   wire [6:0] f7  = ir[31:25];
   wire [4:0] rd  = ir[11:7];
   wire [4:0] rs1 = ir[19:15];
   wire [4:0] rs2 = ir[24:20];

   wire is_load  = (opc == OPC_LOAD);
   wire is_store = (opc == OPC_STORE);

   function automatic logic reg_ok(input logic [4:0] r);
      return {27'd0, r} < 32'(NUM_REGS);
   endfunction

   riscv_regfile #(.NUM_REGS(NUM_REGS)) u_rf (
      .clk(clk), .rst(rst),
      .raddr1(rs1), .raddr2(rs2), .rdata1(rd1), .rdata2(rd2),
      .we(state == S_WB), .waddr(rd), .wdata(is_load ? mdr : alu_out)
   );

   // immediate generator
   always_comb begin
      case (opc)
         OPC_STORE:          imm_sel = IMM_S;
         OPC_BRANCH:         imm_sel = IMM_B;
         OPC_LUI, OPC_AUIPC: imm_sel = IMM_U;
         OPC_JAL:            imm_sel = IMM_J;
         default:            imm_sel = IMM_I;
      endcase
      case (imm_sel)
         IMM_S:   imm = {{20{ir[31]}}, ir[31:25], ir[11:7]};
         IMM_B:   imm = {{19{ir[31]}}, ir[31], ir[7], ir[30:25], ir[11:8], 1'b0};
         IMM_U:   imm = {ir[31:12], 12'd0};
         IMM_J:   imm = {{11{ir[31]}}, ir[31], ir[19:12], ir[20], ir[30:21], 1'b0};
         default: imm = {{20{ir[31]}}, ir[31:20]};
      endcase
   end

   // legality: opcode/funct fields plus every register field the format uses
   always_comb begin
      case (opc)
         OPC_LUI, OPC_AUIPC, OPC_JAL: legal = reg_ok(rd);
         OPC_JALR:   legal = (f3 == F3_ADD) && reg_ok(rd) && reg_ok(rs1);
         OPC_BRANCH: legal = (f3 != 3'b010) && (f3 != 3'b011) && reg_ok(rs1) && reg_ok(rs2);
         OPC_LOAD:   legal = (f3 == F3_WORD) && reg_ok(rd) && reg_ok(rs1);
         OPC_STORE:  legal = (f3 == F3_WORD) && reg_ok(rs1) && reg_ok(rs2);
         OPC_OPIMM:  legal = reg_ok(rd) && reg_ok(rs1) &&
                             ((f3 == F3_SLL) ? (f7 == F7_BASE) :
                              (f3 == F3_SR)  ? (f7 == F7_BASE || f7 == F7_ALT) : 1'b1);
         OPC_OP:     legal = reg_ok(rd) && reg_ok(rs1) && reg_ok(rs2) &&
                             ((f7 == F7_BASE) ||
                              (f7 == F7_ALT && (f3 == F3_ADD || f3 == F3_SR)));
         default:    legal = 1'b0;
      endcase
   end

   // ALU operand select; PC-relative targets share the one adder
   always_comb begin
      alu_a  = a_q;
      alu_b  = imm;
      alu_op = ALU_ADD;
      case (opc)
         OPC_LUI:                        alu_op = ALU_PASSB;
         OPC_AUIPC, OPC_JAL, OPC_BRANCH: alu_a  = PC;
         OPC_OPIMM:  alu_op = alu_dec(f3, (f3 == F3_SR) && ir[30]);
         OPC_OP: begin
            alu_b  = b_q;
            alu_op = alu_dec(f3, ir[30]);
         end
         default: ;
      endcase
      alu_res = alu_exec(alu_op, alu_a, alu_b);
      jtgt    = {alu_res[31:1], alu_res[0] & (opc != OPC_JALR)};
      pc4     = PC + 32'd4;
   end

   // branch condition from the A/B latches
   always_comb begin
      case (f3)
         F3_BEQ:  taken = (a_q == b_q);
         F3_BNE:  taken = (a_q != b_q);
         F3_BLT:  taken = ($signed(a_q) < $signed(b_q));
         F3_BGE:  taken = ($signed(a_q) >= $signed(b_q));
         F3_BLTU: taken = (a_q < b_q);
         F3_BGEU: taken = (a_q >= b_q);
         default: taken = 1'b0;
      endcase
   end

   // main FSM and datapath latches
   always_ff @(posedge clk) begin
      if (!rst) begin
         state   <= S_FETCH;
         in_rst  <= 1'b1;
         PC      <= RESET_PC;
         npc     <= RESET_PC;
         ir      <= '0;
         a_q     <= '0;
         b_q     <= '0;
         alu_out <= '0;
         mdr     <= '0;
      end else begin
         in_rst <= 1'b0;
         case (state)
            S_FETCH: if (!in_rst && mem.mem_ready) begin
               ir    <= mem.mem_rdata;
               state <= S_DECODE;
            end
            S_DECODE: begin
               a_q   <= rd1;
               b_q   <= rd2;
               state <= legal ? S_EXEC : S_HALT;
            end
            S_EXEC: begin
               alu_out <= alu_res;
               npc     <= pc4;
               case (opc)
                  OPC_BRANCH: begin
                     PC    <= taken ? alu_res : pc4;
                     state <= S_FETCH;
                  end
                  OPC_LOAD, OPC_STORE:
                     state <= (alu_res[1:0] != 2'b00) ? S_HALT : S_MEM;
                  OPC_JAL, OPC_JALR:
                     if (jtgt[1:0] != 2'b00) begin
                        state <= S_HALT;
                     end else begin
                        alu_out <= pc4;
                        npc     <= jtgt;
                        state   <= S_WB;
                     end
                  default: state <= S_WB;
               endcase
            end
            S_MEM: if (mem.mem_ready) begin
               if (is_store) begin
                  PC    <= pc4;
                  state <= S_FETCH;
               end else begin
                  mdr   <= mem.mem_rdata;
                  state <= S_WB;
               end
            end
            S_WB: begin
               PC    <= npc;
               state <= S_FETCH;
            end
            default: state <= S_HALT;
         endcase
      end
   end

   assign mem.mem_req   = !in_rst && (state == S_FETCH || state == S_MEM);
   assign mem.mem_we    = (state == S_MEM) && is_store;
   assign mem.mem_addr  = (state == S_MEM) ? alu_out : PC;
   assign mem.mem_wdata = b_q;
   assign halted        = (state == S_HALT);
   // a store completes (and retires) in whichever cycle memory accepts it
   assign retire = (state == S_WB) ||
                   (state == S_EXEC && opc == OPC_BRANCH) ||
                   (state == S_MEM && is_store && mem.mem_ready);
endmodule

// File: tb/tb_riscv_multicycle.sv
// Scoreboard bench: expected retires/stores are queued, a monitor pops on DUT events.
module tb_riscv_multicycle;
   import riscv_pkg::*;

   localparam logic [31:0] RPC = 32'h0000_0040;

   logic clk = 1'b0;
   logic rst = 1'b0;
   logic rst2 = 1'b0;
   always #5 clk = ~clk;

   riscv_multicycle_if bus ();
   riscv_multicycle_if bus2 ();
   logic [31:0] pc, pc2;
   logic retire, halted, retire2, halted2;

   riscv_multicycle #(.RESET_PC(RPC), .NUM_REGS(32)) dut (
      .clk(clk), .rst(rst), .mem(bus), .PC(pc), .retire(retire), .halted(halted));

   riscv_multicycle #(.RESET_PC(32'h0), .NUM_REGS(16)) dut2 (
      .clk(clk), .rst(rst2), .mem(bus2), .PC(pc2), .retire(retire2), .halted(halted2));

   int checks = 0;
   int errors = 0;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   // ---------------- memory models ----------------
   logic [31:0] prog [256];
   logic [31:0] dmem [256];
   bit          dval [256];
   logic [31:0] prog2 [16];
   int          wcnt = 0;

   // two wait states on the SW/LW fetches and on data word 8
   function automatic int ws_of(input logic [31:0] a);
      return ((a >= 32'h50 && a < 32'h58) || a == 32'h8) ? 2 : 0;
   endfunction

   wire [7:0] midx = bus.mem_addr[9:2];
   assign bus.mem_ready = bus.mem_req && (wcnt == ws_of(bus.mem_addr));
   assign bus.mem_rdata = dval[midx] ? dmem[midx] : prog[midx];
   assign bus2.mem_ready = bus2.mem_req;
   assign bus2.mem_rdata = prog2[bus2.mem_addr[5:2]];

   always @(posedge clk) begin
      if (bus.mem_req && !bus.mem_ready) wcnt <= wcnt + 1;
      else wcnt <= 0;
      if (bus.mem_req && bus.mem_we && bus.mem_ready) begin
         dmem[midx] <= bus.mem_wdata;
         dval[midx] <= 1'b1;
      end
   end

   // ---------------- scoreboard ----------------
   typedef struct { logic [31:0] pc; int len; } ret_t;
   typedef struct { logic [31:0] addr; logic [31:0] data; } wr_t;
   ret_t rq[$];
   wr_t  wq[$];

   logic [31:0] exp_pc  [15] = '{32'h40, 32'h44, 32'h48, 32'h4C, 32'h50, 32'h54, 32'h58,
                                 32'h5C, 32'h68, 32'h6C, 32'h70, 32'h68, 32'h6C, 32'h70, 32'h74};
   int          exp_len [15] = '{4, 4, 4, 4, 8, 9, 4, 4, 4, 4, 3, 4, 4, 3, 4};

   task automatic push_prog(input int n);
      for (int i = 0; i < n; i++) begin
         rq.push_back('{pc: exp_pc[i], len: exp_len[i]});
         if (i == 4) wq.push_back('{addr: 32'h8, data: 32'h2});
      end
   endtask

   // ---------------- monitor ----------------
   logic        rst_q = 1'b0;
   int          len = 0;
   logic        pend = 1'b0, prev_act = 1'b0, prev_ret = 1'b0, p_we = 1'b0;
   logic [31:0] p_addr = '0, p_wdata = '0, prev_pc = '0;
   int          ret2 = 0;

   always @(posedge clk) rst_q <= rst;

   always @(negedge clk) begin : mon
      ret_t r;
      wr_t  w;
      int   n;
      n = len + 1;
      if (rst_q) begin
         if (retire) begin
            if (rq.size() == 0) begin
               checks++; errors++;
               $display("FAIL retire_unexpected: got retire at pc %h expected none", pc);
            end else begin
               r = rq.pop_front();
               chk("retire_pc", pc, r.pc);
               chk("retire_len", n, r.len);
            end
         end
         if (bus.mem_req && bus.mem_we && bus.mem_ready) begin
            if (wq.size() == 0) begin
               checks++; errors++;
               $display("FAIL store_unexpected: got store to %h expected none", bus.mem_addr);
            end else begin
               w = wq.pop_front();
               chk("store_addr", bus.mem_addr, w.addr);
               chk("store_data", bus.mem_wdata, w.data);
            end
         end
         if (pend) begin
            chk("hold_req", {31'd0, bus.mem_req}, 32'd1);
            chk("hold_addr", bus.mem_addr, p_addr);
            chk("hold_we", {31'd0, bus.mem_we}, {31'd0, p_we});
            chk("hold_wdata", bus.mem_wdata, p_wdata);
         end
         if (prev_act && pc != prev_pc)
            chk("pc_only_on_retire", {31'd0, prev_ret}, 32'd1);
      end
      len      <= (!rst_q || retire) ? 0 : n;
      pend     <= rst_q && bus.mem_req && !bus.mem_ready;
      p_addr   <= bus.mem_addr;
      p_we     <= bus.mem_we;
      p_wdata  <= bus.mem_wdata;
      prev_pc  <= pc;
      prev_ret <= retire;
      prev_act <= rst_q;
   end

   always @(negedge clk) if (retire2 === 1'b1) ret2 <= ret2 + 1;

   // ---------------- helpers ----------------
   task automatic chk_regs(input string tag, input logic [31:0] e [11]);
      for (int i = 0; i < 11; i++)
         chk($sformatf("%s_x%0d", tag, i), dut.u_rf.rf[i], e[i]);
   endtask

   task automatic wait_halt(input string name, input int max);
      int k = 0;
      while (halted !== 1'b1 && k < max) begin
         @(negedge clk);
         k++;
      end
      chk(name, {31'd0, halted}, 32'd1);
   endtask

   task automatic halt_quiet(input string name);
      int bad = 0;
      repeat (20) begin
         @(negedge clk);
         if (bus.mem_req !== 1'b0 || retire !== 1'b0 || halted !== 1'b1) bad++;
      end
      chk(name, bad, 0);
   endtask

   logic [31:0] zeros [11] = '{default: 32'h0};
   logic [31:0] final_regs [11] = '{32'h0, 32'h60, 32'hFFFF_FFFD, 32'h2, 32'hFFFF_FFF8,
                                   32'h2, 32'h100, 32'h0, 32'h2, 32'h2, 32'h0};

   // ---------------- stimulus ----------------
   initial begin
      int k;
      for (int i = 0; i < 256; i++) prog[i] = 32'h0;
      prog[16] = 32'h00500093;  // 40 addi x1,x0,5
      prog[17] = 32'hFFD00113;  // 44 addi x2,x0,-3
      prog[18] = 32'h002081B3;  // 48 add  x3,x1,x2
      prog[19] = 32'h40110233;  // 4C sub  x4,x2,x1
      prog[20] = 32'h00302423;  // 50 sw   x3,8(x0)
      prog[21] = 32'h00802283;  // 54 lw   x5,8(x0)
      prog[22] = 32'h10000313;  // 58 addi x6,x0,0x100
      prog[23] = 32'h00C000EF;  // 5C jal  x1,+12
      prog[24] = 32'h00100393;  // 60 addi x7,x0,1 (skipped)
      prog[25] = 32'h00100393;  // 64 addi x7,x0,1 (skipped)
      prog[26] = 32'h00140413;  // 68 addi x8,x8,1
      prog[27] = 32'h00200493;  // 6C addi x9,x0,2
      prog[28] = 32'hFE941CE3;  // 70 bne  x8,x9,-8
      prog[29] = 32'h00130067;  // 74 jalr x0,1(x6)
      prog[64] = 32'h00602503;  // 100 lw x10,6(x0): misaligned
      for (int i = 0; i < 16; i++) prog2[i] = 32'h0;
      prog2[0] = 32'h00700013;  // addi x0,x0,7
      prog2[1] = 32'h00300093;  // addi x1,x0,3
      prog2[2] = 32'h00100A13;  // addi x20,x0,1: illegal under RV32E

      rst = 1'b0; rst2 = 1'b0;
      repeat (3) @(negedge clk);
      chk("rst_req", {31'd0, bus.mem_req}, 32'd0);
      chk("rst_we", {31'd0, bus.mem_we}, 32'd0);
      chk("rst_retire", {31'd0, retire}, 32'd0);
      chk("rst_halted", {31'd0, halted}, 32'd0);
      chk("rst_addr", bus.mem_addr, RPC);
      chk("rst_wdata", bus.mem_wdata, 32'd0);
      chk("rst_pc", pc, RPC);
      chk_regs("rst", zeros);

      // run 1: full program, ends in misaligned-load trap
      push_prog(15);
      rst = 1'b1; rst2 = 1'b1;
      @(negedge clk);
      chk("first_fetch_req", {31'd0, bus.mem_req}, 32'd1);
      chk("first_fetch_addr", bus.mem_addr, RPC);
      wait_halt("run1_halt", 400);
      chk("run1_pc", pc, 32'h100);
      chk_regs("run1", final_regs);
      chk("mem_word8", dmem[2], 32'h2);
      chk("run1_rq_empty", rq.size(), 0);
      chk("run1_wq_empty", wq.size(), 0);
      halt_quiet("run1_halt_quiet");

      // RV32E instance: x0 write discarded, x20 reference traps
      chk("e_halted", {31'd0, halted2}, 32'd1);
      chk("e_pc", pc2, 32'h8);
      chk("e_retires", ret2, 2);
      chk("e_x0", dut2.u_rf.rf[0], 32'h0);
      chk("e_x1", dut2.u_rf.rf[1], 32'h3);

      // run 2: reset out of HALT, then reset again during the stalled LW
      push_prog(5);
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      k = 0;
      while (!(bus.mem_req === 1'b1 && bus.mem_we === 1'b0 && bus.mem_addr == 32'h8)
             && k < 200) begin
         @(negedge clk);
         k++;
      end
      chk("lw_stall_seen", {31'd0, bus.mem_ready}, 32'd0);
      chk("lw_stall_addr", bus.mem_addr, 32'h8);
      chk("run2_rq_empty", rq.size(), 0);
      prog[64] = 32'h00000073;  // SYSTEM opcode for run 3
      push_prog(15);
      rst = 1'b0;
      @(negedge clk);
      chk("mid_rst_req", {31'd0, bus.mem_req}, 32'd0);
      chk("mid_rst_pc", pc, RPC);
      chk("mid_rst_halted", {31'd0, halted}, 32'd0);
      chk("mid_rst_wdata", bus.mem_wdata, 32'd0);
      chk_regs("mid_rst", zeros);
      rst = 1'b1;
      @(negedge clk);
      chk("refetch_req", {31'd0, bus.mem_req}, 32'd1);
      chk("refetch_addr", bus.mem_addr, RPC);

      // run 3: full program, ends on illegal SYSTEM opcode
      wait_halt("run3_halt", 400);
      chk("run3_pc", pc, 32'h100);
      chk_regs("run3", final_regs);
      chk("run3_rq_empty", rq.size(), 0);
      chk("run3_wq_empty", wq.size(), 0);
      halt_quiet("run3_halt_quiet");

      $display("Result: errors=%0d of %0d checks", errors, checks);
      $finish;
   end
endmodule
